// File: rtl/fp_to_fixed_pkg.sv
// fp_to_fixed_pkg: shared definitions for the (S,E,F) -> two's-complement expander.
//   Holds the default widths (kept in step with the FPCVT encoder) and the
//   2-bit FSM state encodings used by fp_to_fixed.
package fp_to_fixed_pkg;

  localparam int D_W_DEF = 12;  // reconstructed value width
  localparam int E_W_DEF = 3;   // exponent width
  localparam int F_W_DEF = 4;   // mantissa width

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SIGN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fp_to_fixed_mag_shifter.sv
// fp_mag_shifter: loadable D_W-bit left-shift register with an E_W-bit
//   down-counter. The mantissa is loaded zero-extended and shifted left once
//   per enabled cycle until the counter reaches zero.
// Ports:
//   clk, rst   clock / asynchronous active-high reset
//   load_i     load f_i into the register and e_i into the counter
//   shift_i    shift enable; a shift only happens while the counter is non-zero
//   f_i, e_i   mantissa / shift count to load
//   mag_o      current magnitude
//   done_o     counter has reached zero
module fp_mag_shifter
  import fp_to_fixed_pkg::*;
#(
  parameter int D_W = D_W_DEF,
  parameter int E_W = E_W_DEF,
  parameter int F_W = F_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic           shift_i,
  input  logic [F_W-1:0] f_i,
  input  logic [E_W-1:0] e_i,
  output logic [D_W-1:0] mag_o,
  output logic           done_o
);

  logic [D_W-1:0] mag_q;
  logic [E_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q <= '0;
      cnt_q <= '0;
    end else if (load_i) begin
      mag_q <= D_W'(f_i);
      cnt_q <= e_i;
    end else if (shift_i && (cnt_q != '0)) begin
      mag_q <= mag_q << 1;
      cnt_q <= cnt_q - E_W'(1);
    end
  end

  assign mag_o  = mag_q;
  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fp_to_fixed.sv
// fp_to_fixed: expands a sign/exponent/mantissa word (S,E,F) into a D_W-bit
//   two's-complement value D = +/-(F << E). The magnitude is rebuilt one left
//   shift per clock in fp_mag_shifter; this level owns the handshake FSM,
//   the optional midpoint bias and the negate.
// Ports:
//   clk, rst              clock / asynchronous active-high reset
//   in_valid, in_ready    input handshake (in_ready only in IDLE)
//   S, E, F               sign (1 = negative), exponent, unsigned mantissa
//   out_valid, out_ready  output handshake; D held until accepted
//   D                     reconstructed value
// Optional feature: define FPCVT_MIDPOINT_EN to add 2**(E-1) to non-zero
//   magnitudes with E != 0, giving the centre of the encoder's bin.
// Latency: out_valid rises on the (E+2)th rising edge after the accept edge.
module fp_to_fixed
  import fp_to_fixed_pkg::*;
#(
  parameter int D_W = D_W_DEF,
  parameter int E_W = E_W_DEF,
  parameter int F_W = F_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           S,
  input  logic [E_W-1:0] E,
  input  logic [F_W-1:0] F,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] D
);

  // Largest magnitude F_max << E_max must fit below the sign bit.
  if (D_W < F_W + (1 << E_W)) begin : g_width_chk
    $error("fp_to_fixed: D_W too small for F_W/E_W");
  end

  state_t         state_q;
  logic           in_ready_q;
  logic           out_valid_q;
  logic [D_W-1:0] d_q;
  logic           s_q;

  logic           load;
  logic           shift_en;
  logic [D_W-1:0] mag;
  logic           sh_done;
  logic [D_W-1:0] mag_adj;
  logic [D_W-1:0] d_d;

  assign load     = (state_q == ST_IDLE) && in_valid;
  assign shift_en = (state_q == ST_SHIFT);

  fp_mag_shifter #(.D_W(D_W), .E_W(E_W), .F_W(F_W)) u_shifter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift_en),
    .f_i     (F),
    .e_i     (E),
    .mag_o   (mag),
    .done_o  (sh_done)
  );

`ifdef FPCVT_MIDPOINT_EN
  // The exponent is only needed after loading to place the midpoint bias.
  logic [E_W-1:0] e_q;
  logic [E_W-1:0] e_m1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       e_q <= '0;
    else if (load) e_q <= E;
  end

  assign e_m1 = e_q - E_W'(1);

  // mag != 0 is equivalent to F != 0: shifting never discards set bits.
  always_comb begin
    mag_adj = mag;
    if ((e_q != '0) && (mag != '0))
      mag_adj = mag + (D_W'(1) << e_m1);
  end
`else
  assign mag_adj = mag;
`endif

  // A zero magnitude is passed through untouched so no negative zero appears.
  assign d_d = (s_q && (mag_adj != '0)) ? (-mag_adj) : mag_adj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      d_q         <= '0;
      s_q         <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            s_q        <= S;
            in_ready_q <= 1'b0;
            state_q    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // The shifter steps on its own while enabled; move on once drained.
          if (sh_done) state_q <= ST_SIGN;
        end
        ST_SIGN: begin
          d_q         <= d_d;
          out_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign D         = d_q;

endmodule

// File: tb/tb_fp_to_fixed.sv
// tb_fp_to_fixed: directed cases plus randomized traffic for fp_to_fixed.
//   A transaction-level model (idle / busy for E+2 edges / holding) tracks the
//   expected outputs and is compared against the DUT on every falling edge.
module tb_fp_to_fixed;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        S = 1'b0;
  logic [2:0]  E = '0;
  logic [3:0]  F = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [11:0] D;

  fp_to_fixed dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .S         (S),
    .E         (E),
    .F         (F),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .D         (D)
  );

  always #5 clk = ~clk;

`ifdef FPCVT_MIDPOINT_EN
  localparam bit MID = 1'b1;
`else
  localparam bit MID = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  // Plain arithmetic value of a word, truncated to 12-bit two's complement.
  function automatic logic [11:0] exp_d(input bit s, input int e, input int f);
    int m;
    m = f << e;
    if (MID && e != 0 && f != 0) m += (1 << (e - 1));
    if (s) m = -m;
    return m[11:0];
  endfunction

  // Behavioural model: 0 idle, 1 converting (left edges to go), 2 holding result.
  int          m_phase = 0;
  int          m_left  = 0;
  logic [11:0] m_D     = '0;
  logic [11:0] m_exp   = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_left  = 0;
      m_D     = '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
             m_exp   = exp_d(S, int'(E), int'(F));
             m_left  = int'(E) + 2;
             m_phase = 1;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_D     = m_exp;
               m_phase = 2;
             end
           end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    chk("cyc_in_ready", in_ready, (m_phase == 0));
    chk("cyc_out_valid", out_valid, (m_phase == 2));
    chk("cyc_D", D, m_D);
  end

  // Send one word and check latency, value, hold behaviour and release.
  // noise: keep in_valid high with junk while busy (must be ignored).
  task automatic run(input bit s, input bit [2:0] e, input bit [3:0] f,
                     input logic [11:0] want, input int lat, input int hold,
                     input bit noise);
    int w;
    int n;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    chk("accept_wait", (w < 50), 1);
    in_valid = 1'b1; S = s; E = e; F = f;
    @(posedge clk); #1;
    in_valid = 1'b0; S = ~s; E = 3'($urandom); F = 4'($urandom);
    n = 0;
    while (!out_valid && n < 40) begin
      chk("busy_in_ready", in_ready, 0);
      if (noise) begin
        in_valid = 1'b1; S = 1'($urandom); E = 3'($urandom); F = 4'($urandom);
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    chk("latency", n, lat);
    chk("result_D", D, want);
    repeat (hold) begin
      @(posedge clk); #1;
      chk("hold_D", D, want);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("release_in_ready", in_ready, 1);
    chk("release_out_valid", out_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_D", D, 0);
    rst = 1'b0;

    // Pin the model with hand-computed values.
    chk("model_t1", exp_d(0, 2, 11), MID ? 12'h02E : 12'h02C);
    chk("model_t2", exp_d(1, 0, 1), 12'hFFF);
    chk("model_t3", exp_d(1, 7, 15), MID ? 12'h840 : 12'h880);
    chk("model_t4", exp_d(1, 3, 0), 12'h000);

    run(1'b0, 3'd2, 4'b1011, MID ? 12'h02E : 12'h02C, 4, 0, 1'b0);
    run(1'b1, 3'd0, 4'd1,    12'hFFF,                  2, 0, 1'b0);
    run(1'b1, 3'd7, 4'd15,   MID ? 12'h840 : 12'h880,  9, 0, 1'b0);
    run(1'b1, 3'd3, 4'd0,    12'h000,                  5, 0, 1'b1);
    // Backpressure: 5 << 1 = 10 (11 with midpoint), held for 5 cycles.
    run(1'b0, 3'd1, 4'd5,    MID ? 12'h00B : 12'h00A,  3, 5, 1'b0);

    // Reset during SHIFT of an E=7 word aborts it.
    in_valid = 1'b1; S = 1'b0; E = 3'd7; F = 4'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_D", D, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    // -(3 << 5) = -96 (-112 with midpoint).
    run(1'b1, 3'd5, 4'd3, MID ? 12'hF90 : 12'hFA0, 7, 0, 1'b0);

    // Random traffic, stalls and occasional resets; the per-cycle checker judges it.
    repeat (3000) begin
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      S         = 1'($urandom);
      E         = 3'($urandom);
      F         = 4'($urandom);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
